// File: rtl/bit8_1to4demux_buf.sv
// ---------------------------------------------------------------------------
// bit8_1to4demux_buf
//   1-to-4 demultiplexer with a one-entry buffer on every output channel.
//   A source word is steered by {sel1,sel2} into one channel. The channel
//   holds it until its sink takes it. Each channel counts the words it has
//   delivered.
//
// Ports
//   clk, rst_n             clock / asynchronous active-low reset
//   in, in_valid, in_ready source handshake (in_ready is combinational)
//   sel1, sel2             destination index {sel1,sel2}: 00->out1 .. 11->out4
//   outN, outN_valid       per-channel held word and FULL flag
//   outN_ready             per-channel sink handshake
//   cntN                   per-channel delivery counters (wrapping)
// ---------------------------------------------------------------------------

// One channel: EMPTY/FULL buffer plus delivery counter.
module bit8_1to4demux_buf_chan #(
    parameter int WIDTH = 8,
    parameter int CNTW  = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_load,   // source transfer steered to this channel
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_ready,  // sink takes the word this cycle
    output logic [WIDTH-1:0] o_data,
    output logic             o_valid,
    output logic [CNTW-1:0]  o_cnt
);
    localparam logic [0:0] ST_EMPTY = 1'b0;
    localparam logic [0:0] ST_FULL  = 1'b1;

    logic [0:0]       r_state;
    logic [WIDTH-1:0] r_data;
    logic [CNTW-1:0]  r_cnt;
    logic             w_dlv;

    assign w_dlv = (r_state == ST_FULL) && i_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_EMPTY;
            r_data  <= '0;
            r_cnt   <= '0;
        end else begin
            // A load wins over a delivery: on a same-edge refill the channel
            // stays FULL holding the new word.
            if (i_load) begin
                r_state <= ST_FULL;
                r_data  <= i_data;
            end else if (w_dlv) begin
                r_state <= ST_EMPTY;
            end
            if (w_dlv)
                r_cnt <= r_cnt + CNTW'(1);
        end
    end

    assign o_data  = r_data;
    assign o_valid = (r_state == ST_FULL);
    assign o_cnt   = r_cnt;
endmodule

module bit8_1to4demux_buf #(
    parameter int WIDTH = 8,
    parameter int CNTW  = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] in,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             sel1,
    input  logic             sel2,
    output logic [WIDTH-1:0] out1,
    output logic [WIDTH-1:0] out2,
    output logic [WIDTH-1:0] out3,
    output logic [WIDTH-1:0] out4,
    output logic             out1_valid,
    output logic             out2_valid,
    output logic             out3_valid,
    output logic             out4_valid,
    input  logic             out1_ready,
    input  logic             out2_ready,
    input  logic             out3_ready,
    input  logic             out4_ready,
    output logic [CNTW-1:0]  cnt1,
    output logic [CNTW-1:0]  cnt2,
    output logic [CNTW-1:0]  cnt3,
    output logic [CNTW-1:0]  cnt4
);
    localparam int NUM_CH = 4;

    logic [1:0]                    w_sel;
    logic [NUM_CH-1:0]             w_rdy;
    logic [NUM_CH-1:0]             w_full;
    logic [NUM_CH-1:0]             w_load;
    logic [NUM_CH-1:0][WIDTH-1:0]  w_data;
    logic [NUM_CH-1:0][CNTW-1:0]   w_cnt;

    assign w_sel = {sel1, sel2};
    assign w_rdy = {out4_ready, out3_ready, out2_ready, out1_ready};

    // Ready looks only at the selected channel, never at in_valid, so a
    // source may change sel while waiting and the word follows the new sel.
    assign in_ready = ~w_full[w_sel] | w_rdy[w_sel];

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        assign w_load[g] = in_valid & in_ready & (w_sel == 2'(g));

        bit8_1to4demux_buf_chan #(
            .WIDTH (WIDTH),
            .CNTW  (CNTW)
        ) u_chan (
            .clk     (clk),
            .rst_n   (rst_n),
            .i_load  (w_load[g]),
            .i_data  (in),
            .i_ready (w_rdy[g]),
            .o_data  (w_data[g]),
            .o_valid (w_full[g]),
            .o_cnt   (w_cnt[g])
        );
    end

    assign {out4, out3, out2, out1}                         = w_data;
    assign {out4_valid, out3_valid, out2_valid, out1_valid} = w_full;
    assign {cnt4, cnt3, cnt2, cnt1}                         = w_cnt;
endmodule

// File: tb/tb_bit8_1to4demux_buf.sv
// ---------------------------------------------------------------------------
// tb_bit8_1to4demux_buf
//   Directed bench. Accepted words go into a per-channel scoreboard queue and
//   are popped and compared when the channel delivers. A small model of the
//   FULL flags and counters predicts in_ready, valids and counts.
// ---------------------------------------------------------------------------
module tb_bit8_1to4demux_buf;
    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] d_in;
    logic       in_valid, in_ready, sel1, sel2;
    logic [7:0] out1, out2, out3, out4;
    logic       out1_valid, out2_valid, out3_valid, out4_valid;
    logic       out1_ready, out2_ready, out3_ready, out4_ready;
    logic [7:0] cnt1, cnt2, cnt3, cnt4;

    always #5 clk = ~clk;

    bit8_1to4demux_buf #(.WIDTH(8), .CNTW(8)) dut (
        .clk(clk), .rst_n(rst_n), .in(d_in), .in_valid(in_valid), .in_ready(in_ready),
        .sel1(sel1), .sel2(sel2),
        .out1(out1), .out2(out2), .out3(out3), .out4(out4),
        .out1_valid(out1_valid), .out2_valid(out2_valid),
        .out3_valid(out3_valid), .out4_valid(out4_valid),
        .out1_ready(out1_ready), .out2_ready(out2_ready),
        .out3_ready(out3_ready), .out4_ready(out4_ready),
        .cnt1(cnt1), .cnt2(cnt2), .cnt3(cnt3), .cnt4(cnt4)
    );

    logic [3:0][7:0] v_out, v_cnt;
    logic [3:0]      v_vld, v_rdy;
    assign v_out = {out4, out3, out2, out1};
    assign v_cnt = {cnt4, cnt3, cnt2, cnt1};
    assign v_vld = {out4_valid, out3_valid, out2_valid, out1_valid};
    assign v_rdy = {out4_ready, out3_ready, out2_ready, out1_ready};

    int         n_asrt = 0;
    int         n_fail = 0;
    logic [7:0] sbq [4][$];
    logic [3:0] m_full;
    logic [7:0] m_cnt [4];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_asrt++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        for (int c = 0; c < 4; c++) begin
            sbq[c].delete();
            m_cnt[c] = 8'h00;
        end
        m_full = 4'h0;
    endtask

    task automatic rst_chk(input string tag);
        for (int c = 0; c < 4; c++) begin
            chk({tag, "_valid"}, 32'(v_vld[c]), 32'd0);
            chk({tag, "_data"},  32'(v_out[c]), 32'd0);
            chk({tag, "_cnt"},   32'(v_cnt[c]), 32'd0);
        end
        chk({tag, "_in_ready"}, 32'(in_ready), 32'd1);
    endtask

    // Called just after a rising edge with inputs already driven; checks the
    // combinational ready and delivered data before the next edge, then the
    // registered state just after it.
    task automatic cycle();
        int         s;
        logic       acc;
        logic [7:0] exp;
        #1;
        s   = int'({sel1, sel2});
        acc = !m_full[s] || v_rdy[s];
        chk("in_ready", 32'(in_ready), 32'(acc));
        for (int c = 0; c < 4; c++) begin
            if (m_full[c] && v_rdy[c]) begin
                exp = sbq[c].pop_front();
                chk("dlv_data", 32'(v_out[c]), 32'(exp));
                m_cnt[c]  = m_cnt[c] + 8'd1;
                m_full[c] = 1'b0;
            end
        end
        if (in_valid && acc) begin
            sbq[s].push_back(d_in);
            m_full[s] = 1'b1;
        end
        @(posedge clk);
        #1;
        for (int c = 0; c < 4; c++) begin
            chk("valid", 32'(v_vld[c]), 32'(m_full[c]));
            chk("cnt",   32'(v_cnt[c]), 32'(m_cnt[c]));
            if (m_full[c])
                chk("held_data", 32'(v_out[c]), 32'(sbq[c][0]));
        end
    endtask

    task automatic drive(input logic v, input logic [1:0] s, input logic [7:0] d);
        in_valid = v;
        {sel1, sel2} = s;
        d_in = d;
    endtask

    initial begin
        model_clear();
        rst_n = 1'b0;
        drive(1'b0, 2'b00, 8'h00);
        {out4_ready, out3_ready, out2_ready, out1_ready} = 4'h0;
        #2;
        rst_chk("rst_async");
        @(posedge clk);
        #1;
        rst_chk("rst_held");
        rst_n = 1'b1;

        // Single word to out3, one cycle latency, first valid after reset.
        drive(1'b1, 2'b10, 8'hA5);
        cycle();
        chk("a5_out3", 32'(out3), 32'hA5);
        drive(1'b0, 2'b10, 8'h00);
        out3_ready = 1'b1;
        cycle();
        out3_ready = 1'b0;

        // Backpressure on out2 for 5 cycles, then same-edge refill.
        drive(1'b1, 2'b01, 8'h5A);
        cycle();
        drive(1'b1, 2'b01, 8'h66);
        for (int i = 0; i < 5; i++) cycle();
        out2_ready = 1'b1;
        cycle();
        chk("refill_out2", 32'(out2), 32'h66);
        chk("refill_cnt2", 32'(cnt2), 32'd1);
        drive(1'b0, 2'b01, 8'h00);
        cycle();
        out2_ready = 1'b0;

        // Pending word blocked on out1 follows a sel change to out2.
        drive(1'b1, 2'b00, 8'h31);
        cycle();
        drive(1'b1, 2'b00, 8'h42);
        cycle();
        drive(1'b1, 2'b01, 8'h42);
        cycle();
        chk("redirect_out2", 32'(out2), 32'h42);
        drive(1'b0, 2'b00, 8'h00);
        {out2_ready, out1_ready} = 2'b11;
        cycle();
        {out2_ready, out1_ready} = 2'b00;

        // Back-to-back fill of all four channels with sinks stalled.
        drive(1'b1, 2'b00, 8'h11); cycle();
        drive(1'b1, 2'b01, 8'h22); cycle();
        drive(1'b1, 2'b10, 8'h33); cycle();
        drive(1'b1, 2'b11, 8'h44); cycle();
        chk("fill_all", 32'(v_vld), 32'hF);

        // Simultaneous deliveries on out1/out4 with refill of out1.
        drive(1'b1, 2'b00, 8'h77);
        {out4_ready, out1_ready} = 2'b11;
        cycle();
        {out4_ready, out1_ready} = 2'b00;
        chk("dual_out1", 32'(out1), 32'h77);
        chk("dual_vld4", 32'(out4_valid), 32'd0);

        // Refill out4 so all four are FULL, then reset between edges.
        drive(1'b1, 2'b11, 8'h88);
        cycle();
        drive(1'b0, 2'b00, 8'h00);
        chk("pre_rst_full", 32'(v_vld), 32'hF);
        #2;
        rst_n = 1'b0;
        #1;
        rst_chk("rst_mid");
        model_clear();
        #1;
        rst_n = 1'b1;

        // 256 deliveries on out4 wrap cnt4 back to 0.
        out4_ready = 1'b1;
        for (int i = 0; i < 256; i++) begin
            drive(1'b1, 2'b11, 8'(i * 7 + 3));
            cycle();
        end
        drive(1'b0, 2'b11, 8'h00);
        cycle();
        out4_ready = 1'b0;
        chk("cnt4_wrap", 32'(cnt4), 32'd0);
        chk("cnt1_zero", 32'(cnt1), 32'd0);
        chk("cnt3_zero", 32'(cnt3), 32'd0);
        chk("out4_empty", 32'(out4_valid), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
        $finish;
    end
endmodule

// File: doc/bit8_1to4demux_buf.md
BIT8_1TO4DEMUX_BUF -- requirements
Module: bit8_1to4demux_buf

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, giving the data path width in bits.
REQ-002 The block SHALL have parameter CNTW, default 8, giving the width of each per-channel delivery counter.
REQ-003 Port clk, input, 1 bit: the single clock; all state updates on the rising edge.
REQ-004 Port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-005 Port in, input, WIDTH bits: source data word.
REQ-006 Port in_valid, input, 1 bit: source word present.
REQ-007 Port in_ready, output, 1 bit: block accepts the source word this cycle.
REQ-008 Ports sel1 and sel2, input, 1 bit each: destination select, index {sel1,sel2}; 00 selects out1, 01 out2, 10 out3, 11 out4.
REQ-009 Ports out1 to out4, output, WIDTH bits each: per-channel held data.
REQ-010 Ports out1_valid to out4_valid, output, 1 bit each: channel holds an undelivered word.
REQ-011 Ports out1_ready to out4_ready, input, 1 bit each: sink takes the channel word this cycle.
REQ-012 Ports cnt1 to cnt4, output, CNTW bits each: number of words delivered on each channel.

Function
REQ-013 Each channel SHALL be a one-entry buffer with two states, EMPTY (outN_valid=0) and FULL (outN_valid=1).
REQ-014 A source transfer SHALL occur on a rising edge where in_valid=1 and in_ready=1.
REQ-015 A channel delivery SHALL occur on a rising edge where outN_valid=1 and outN_ready=1.
REQ-016 in_ready SHALL be combinational: 1 when the selected channel is EMPTY, or when it is FULL and its outN_ready=1 in the same cycle (pass-through refill).
REQ-017 On a transfer, the selected channel SHALL capture in and enter FULL on that edge, giving one cycle of latency from source to outN_valid.
REQ-018 On a delivery with no simultaneous refill of that channel, the channel SHALL return to EMPTY.
REQ-019 On a delivery with a simultaneous refill of the same channel, the channel SHALL stay FULL and hold the new word.
REQ-020 Unselected channels SHALL be unaffected by in, in_valid and sel1/sel2.
REQ-021 outN SHALL hold its last value while EMPTY; sinks ignore it.
REQ-022 outN and outN_valid SHALL stay stable while FULL and outN_ready=0.
REQ-023 cntN SHALL increment by 1 on each delivery on channel N and wrap from 2^CNTW-1 to 0.
REQ-024 Deliveries on several channels in the same cycle SHALL each be counted independently.
REQ-025 sel1/sel2 SHALL be sampled only when a transfer occurs; a change while in_valid=1 and in_ready=0 redirects the pending word to the new channel.
REQ-026 in_ready SHALL not depend on in_valid.

Reset
REQ-027 While rst_n=0, regardless of clk: all outN_valid=0, all outN=0, all cntN=0; in_ready SHALL then reflect channel EMPTY, i.e. 1.
REQ-028 Reset asserted mid-operation SHALL discard all buffered words without delivering them and without counting them.
REQ-029 After rst_n deasserts, the first transfer SHALL be accepted on the first rising edge with in_valid=1.

Verification
REQ-030 Reset, then in=8'hA5, sel=10, in_valid=1 for one cycle -> next cycle out3=8'hA5, out3_valid=1; other channels have valid=0.
REQ-031 out2 FULL, out2_ready=0, in_valid=1, sel=01 -> in_ready=0 and out2 is held for 5 cycles; then out2_ready=1 -> same-edge refill, out2 shows the new word, cnt2=1.
REQ-032 Four back-to-back words 11,22,33,44 to sel 00,01,10,11 with all outN_ready=0 -> all four channels FULL with matching data, in_ready=1 each cycle.
REQ-033 256 deliveries on channel 4 (CNTW=8) -> cnt4 wraps to 0; cnt1 to cnt3 stay 0.
REQ-034 All four channels FULL, then rst_n pulsed low between clock edges -> all valid and count outputs 0 immediately, before the next edge.
REQ-035 Simultaneous out1_ready=1, out4_ready=1 with both FULL, plus a source transfer to sel=00 -> cnt1 and cnt4 each +1, out1 FULL with the new word, out4 EMPTY.
